eth_stats_collector_counters: RTL and testbench

- Upstream feeder of the stats AXIS log stage.
- Passively taps the TX and RX AXI-Stream frame paths and accumulates 64-bit byte, good-frame and bad-frame totals per direction.
- Runs a programmable sample timer that emits a one-cycle trigger together with a coherent snapshot of every counter and the timestamp.
- The log stage packs the snapshot into a log record.

---
 rtl/eth_stats_collector_counters.sv | 178 +++++++++++++++++
 tb/tb_eth_stats_collector_counters.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_stats_collector_counters.sv
// eth_stats_collector_counters
//   Passive TX/RX AXI-Stream tap statistics. Accumulates 64-bit byte,
//   good-frame and bad-frame totals per direction, and on a programmable
//   sample timer emits a one-cycle trigger with a coherent snapshot of all
//   counters and a free-running 64-bit timestamp.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   enable                        counting/sampling enable
//   clear                         sync clear of live counters, accumulators, timer
//   sample_period[31:0]           trigger period in cycles, 0 disables trigger
//   s_axis_{tx,rx}_*              observe-only tap (tkeep/tvalid/tready/tlast/tuser)
//   trigger                       one-cycle sample strobe
//   current_time[63:0]            snapshot timestamp
//   {tx,rx}_{bytes,good,bad}      snapshot counters, held between triggers

// One tap direction: per-frame accumulator plus live 64-bit totals.
// The *_nxt outputs are the live counters' next-state values so the top
// level can snapshot a frame that completes in the trigger cycle.
module eth_stats_dir #(
    parameter int C_DATA_BYTES      = 1,
    parameter int C_FRAME_ACC_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    clear,
    input  logic [C_DATA_BYTES-1:0] tkeep,
    input  logic                    tvalid,
    input  logic                    tready,
    input  logic                    tlast,
    input  logic                    tuser,
    output logic [63:0]             bytes_nxt,
    output logic [63:0]             good_nxt,
    output logic [63:0]             bad_nxt
);
    localparam int BW = $clog2(C_DATA_BYTES + 1);
    localparam int AW = C_FRAME_ACC_WIDTH;

    logic [AW-1:0] acc_q, acc_nxt;
    logic [63:0]   bytes_q, good_q, bad_q;
    logic [BW-1:0] beat_bytes;
    logic [AW:0]   acc_sum;
    logic [AW-1:0] acc_sat;
    logic [63:0]   frame_bytes;
    logic          beat, commit;

    always_comb begin
        beat_bytes = '0;
        for (int i = 0; i < C_DATA_BYTES; i++)
            beat_bytes = beat_bytes + BW'(tkeep[i]);
    end

    assign beat        = tvalid & tready;
    assign acc_sum     = {1'b0, acc_q} + (AW+1)'(beat_bytes);
    assign acc_sat     = acc_sum[AW] ? '1 : acc_sum[AW-1:0];
    // Completed frame length uses the unsaturated final beat on top of acc.
    assign frame_bytes = 64'(acc_q) + 64'(beat_bytes);
    // Frames are kept only if enable is high on their tlast beat; clear wins.
    assign commit      = beat & tlast & enable & ~clear;

    always_comb begin
        bytes_nxt = bytes_q;
        good_nxt  = good_q;
        bad_nxt   = bad_q;
        acc_nxt   = acc_q;
        if (clear) begin
            bytes_nxt = '0;
            good_nxt  = '0;
            bad_nxt   = '0;
            acc_nxt   = '0;
        end else begin
            if (beat)
                acc_nxt = tlast ? '0 : acc_sat;
            if (commit) begin
                bytes_nxt = bytes_q + frame_bytes;
                if (tuser) bad_nxt  = bad_q + 64'd1;
                else       good_nxt = good_q + 64'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            bytes_q <= '0;
            good_q  <= '0;
            bad_q   <= '0;
        end else begin
            acc_q   <= acc_nxt;
            bytes_q <= bytes_nxt;
            good_q  <= good_nxt;
            bad_q   <= bad_nxt;
        end
    end
endmodule

module eth_stats_collector_counters #(
    parameter int C_DATA_BYTES      = 1,
    parameter int C_FRAME_ACC_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    clear,
    input  logic [31:0]             sample_period,
    input  logic [C_DATA_BYTES-1:0] s_axis_tx_tkeep,
    input  logic                    s_axis_tx_tvalid,
    input  logic                    s_axis_tx_tready,
    input  logic                    s_axis_tx_tlast,
    input  logic                    s_axis_tx_tuser,
    input  logic [C_DATA_BYTES-1:0] s_axis_rx_tkeep,
    input  logic                    s_axis_rx_tvalid,
    input  logic                    s_axis_rx_tready,
    input  logic                    s_axis_rx_tlast,
    input  logic                    s_axis_rx_tuser,
    output logic                    trigger,
    output logic [63:0]             current_time,
    output logic [63:0]             tx_bytes,
    output logic [63:0]             tx_good,
    output logic [63:0]             tx_bad,
    output logic [63:0]             rx_bytes,
    output logic [63:0]             rx_good,
    output logic [63:0]             rx_bad
);
    logic [63:0] ts_q;
    logic [31:0] timer_q;
    logic        run, fire;
    logic [63:0] tx_bytes_nxt, tx_good_nxt, tx_bad_nxt;
    logic [63:0] rx_bytes_nxt, rx_good_nxt, rx_bad_nxt;

    eth_stats_dir #(.C_DATA_BYTES(C_DATA_BYTES), .C_FRAME_ACC_WIDTH(C_FRAME_ACC_WIDTH)) u_tx (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
        .tkeep(s_axis_tx_tkeep), .tvalid(s_axis_tx_tvalid), .tready(s_axis_tx_tready),
        .tlast(s_axis_tx_tlast), .tuser(s_axis_tx_tuser),
        .bytes_nxt(tx_bytes_nxt), .good_nxt(tx_good_nxt), .bad_nxt(tx_bad_nxt)
    );

    eth_stats_dir #(.C_DATA_BYTES(C_DATA_BYTES), .C_FRAME_ACC_WIDTH(C_FRAME_ACC_WIDTH)) u_rx (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
        .tkeep(s_axis_rx_tkeep), .tvalid(s_axis_rx_tvalid), .tready(s_axis_rx_tready),
        .tlast(s_axis_rx_tlast), .tuser(s_axis_rx_tuser),
        .bytes_nxt(rx_bytes_nxt), .good_nxt(rx_good_nxt), .bad_nxt(rx_bad_nxt)
    );

    assign run  = enable & (sample_period != 32'd0);
    // >= rather than == so lowering the period below the count fires at once.
    assign fire = run & ~clear & (timer_q >= sample_period - 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q         <= '0;
            timer_q      <= '0;
            trigger      <= 1'b0;
            current_time <= '0;
            tx_bytes     <= '0;
            tx_good      <= '0;
            tx_bad       <= '0;
            rx_bytes     <= '0;
            rx_good      <= '0;
            rx_bad       <= '0;
        end else begin
            ts_q    <= ts_q + 64'd1;
            trigger <= fire;
            if (clear || !run || fire) timer_q <= '0;
            else                       timer_q <= timer_q + 32'd1;
            if (fire) begin
                current_time <= ts_q;
                tx_bytes     <= tx_bytes_nxt;
                tx_good      <= tx_good_nxt;
                tx_bad       <= tx_bad_nxt;
                rx_bytes     <= rx_bytes_nxt;
                rx_good      <= rx_good_nxt;
                rx_bad       <= rx_bad_nxt;
            end
        end
    end
endmodule

// File: tb/tb_eth_stats_collector_counters.sv
module tb_eth_stats_collector_counters;
    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          clear = 1'b0;
    logic [31:0]   sample_period = 32'd0;
    logic [DB-1:0] tx_keep = '0, rx_keep = '0;
    logic          tx_valid = 1'b0, tx_ready = 1'b1, tx_last = 1'b0, tx_user = 1'b0;
    logic          rx_valid = 1'b0, rx_ready = 1'b1, rx_last = 1'b0, rx_user = 1'b0;
    logic          trigger;
    logic [63:0]   current_time, tx_bytes, tx_good, tx_bad, rx_bytes, rx_good, rx_bad;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    eth_stats_collector_counters #(.C_DATA_BYTES(DB), .C_FRAME_ACC_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .sample_period(sample_period),
        .s_axis_tx_tkeep(tx_keep), .s_axis_tx_tvalid(tx_valid), .s_axis_tx_tready(tx_ready),
        .s_axis_tx_tlast(tx_last), .s_axis_tx_tuser(tx_user),
        .s_axis_rx_tkeep(rx_keep), .s_axis_rx_tvalid(rx_valid), .s_axis_rx_tready(rx_ready),
        .s_axis_rx_tlast(rx_last), .s_axis_rx_tuser(rx_user),
        .trigger(trigger), .current_time(current_time),
        .tx_bytes(tx_bytes), .tx_good(tx_good), .tx_bad(tx_bad),
        .rx_bytes(rx_bytes), .rx_good(rx_good), .rx_bad(rx_bad)
    );

    // ---------------- reference model (frame-level bookkeeping) ----------------
    longint unsigned m_bytes[2], m_good[2], m_bad[2], m_acc[2];
    longint unsigned s_bytes[2], s_good[2], s_bad[2], s_time;
    longint unsigned m_ts, m_since;
    bit              m_trig;
    localparam longint unsigned ACC_MAX = 64'hFFFF_FFFF;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_bytes[d] = 0; m_good[d] = 0; m_bad[d] = 0; m_acc[d] = 0;
                s_bytes[d] = 0; s_good[d] = 0; s_bad[d] = 0;
            end
            s_time = 0; m_ts = 0; m_since = 0; m_trig = 0;
        end else begin
            bit v[2], l[2], u[2];
            longint unsigned n[2];
            longint unsigned now;
            v[0] = tx_valid & tx_ready; l[0] = tx_last; u[0] = tx_user; n[0] = $countones(tx_keep);
            v[1] = rx_valid & rx_ready; l[1] = rx_last; u[1] = rx_user; n[1] = $countones(rx_keep);
            now = m_ts;
            m_ts = m_ts + 1;
            m_trig = 0;
            if (clear) begin
                for (int d = 0; d < 2; d++) begin
                    m_bytes[d] = 0; m_good[d] = 0; m_bad[d] = 0; m_acc[d] = 0;
                end
                m_since = 0;
            end else begin
                for (int d = 0; d < 2; d++) begin
                    if (v[d] && l[d]) begin
                        if (enable) begin
                            m_bytes[d] += m_acc[d] + n[d];
                            if (u[d]) m_bad[d]++; else m_good[d]++;
                        end
                        m_acc[d] = 0;
                    end else if (v[d]) begin
                        m_acc[d] = (m_acc[d] + n[d] > ACC_MAX) ? ACC_MAX : m_acc[d] + n[d];
                    end
                end
                // m_since = cycles elapsed in the current sampling interval
                if (!enable || sample_period == 0) m_since = 0;
                else if (m_since + 1 >= longint'(sample_period)) begin
                    m_since = 0;
                    m_trig = 1;
                    s_time = now;
                    for (int d = 0; d < 2; d++) begin
                        s_bytes[d] = m_bytes[d]; s_good[d] = m_good[d]; s_bad[d] = m_bad[d];
                    end
                end else m_since++;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_trigger", {63'd0, trigger}, {63'd0, m_trig});
            chk("m_time", current_time, s_time);
            chk("m_tx_bytes", tx_bytes, s_bytes[0]);
            chk("m_tx_good", tx_good, s_good[0]);
            chk("m_tx_bad", tx_bad, s_bad[0]);
            chk("m_rx_bytes", rx_bytes, s_bytes[1]);
            chk("m_rx_good", rx_good, s_good[1]);
            chk("m_rx_bad", rx_bad, s_bad[1]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tx_valid = 0; tx_last = 0; tx_user = 0; tx_keep = '0; tx_ready = 1;
        rx_valid = 0; rx_last = 0; rx_user = 0; rx_keep = '0; rx_ready = 1;
    endtask

    task automatic tx_beat(input logic [DB-1:0] k, input logic last, input logic user);
        tx_valid = 1; tx_keep = k; tx_last = last; tx_user = user;
        tick();
        idle();
    endtask

    task automatic do_clear();
        clear = 1;
        tick();
        clear = 0;
    endtask

    // Ticks until trigger is seen; n = ticks taken. Timeout counts as a failure.
    task automatic wait_trig(input int maxc, output int n);
        n = 0;
        while (n < maxc) begin
            tick();
            n++;
            if (trigger) return;
        end
        checks++;
        failures++;
        $display("FAIL wait_trig timeout after %0d cycles, trigger never seen", maxc);
    endtask

    logic [DB-1:0] bp_keep [0:8] = '{8'hFF, 8'h01, 8'hFF, 8'h03, 8'h07, 8'hFF, 8'hFF, 8'h0F, 8'hFF};
    logic          bp_rdy  [0:8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        int n, cnt;
        // reset state
        tick(); tick();
        chk("rst_trigger", {63'd0, trigger}, 64'd0);
        chk("rst_tx_bytes", tx_bytes, 64'd0);
        chk("rst_time", current_time, 64'd0);
        rst_n = 1;
        enable = 1; sample_period = 32'd10;
        for (int i = 0; i < 25; i++) tick();
        tx_beat(8'hFF, 1, 0);
        wait_trig(20, n);
        // reset mid-run: snapshot outputs go to 0 immediately
        rst_n = 0; enable = 0;
        #1;
        chk("midrst_time", current_time, 64'd0);
        chk("midrst_tx_bytes", tx_bytes, 64'd0);
        chk("midrst_tx_good", tx_good, 64'd0);
        tick();
        rst_n = 1;
        tick();
        // first trigger on 10th edge after enable
        enable = 1;
        for (int i = 0; i < 9; i++) tick();
        chk("first_trig_early", {63'd0, trigger}, 64'd0);
        tick();
        chk("first_trig", {63'd0, trigger}, 64'd1);
        chk("first_tx_bytes", tx_bytes, 64'd0);
        for (int i = 0; i < 10; i++) tick();
        chk("second_trig", {63'd0, trigger}, 64'd1);

        // good TX frame: 8+8+4 bytes
        tx_beat(8'hFF, 0, 0); tx_beat(8'hFF, 0, 0); tx_beat(8'h0F, 1, 0);
        wait_trig(20, n);
        chk("good_tx_bytes", tx_bytes, 64'd20);
        chk("good_tx_good", tx_good, 64'd1);
        chk("good_tx_bad", tx_bad, 64'd0);
        chk("good_rx_bytes", rx_bytes, 64'd0);

        // both directions complete on the trigger edge (clear edge + 10)
        do_clear();
        tick(); tick();
        for (int i = 0; i < 8; i++) begin
            tx_valid = 1; tx_keep = (i == 7) ? 8'h0F : 8'hFF; tx_last = (i == 7); tx_user = 0;
            rx_valid = 1; rx_keep = 8'hFF; rx_last = (i == 7); rx_user = (i == 7);
            tick();
        end
        idle();
        chk("coin_trig", {63'd0, trigger}, 64'd1);
        chk("coin_rx_bytes", rx_bytes, 64'd64);
        chk("coin_rx_bad", rx_bad, 64'd1);
        chk("coin_tx_bytes", tx_bytes, 64'd60);
        chk("coin_tx_good", tx_good, 64'd1);

        // backpressure gaps on RX: accepted beats 1+2+3+4+8 = 18
        do_clear();
        for (int i = 0; i < 9; i++) begin
            rx_valid = 1; rx_keep = bp_keep[i]; rx_ready = bp_rdy[i];
            rx_last = (i == 8); rx_user = 0;
            tick();
        end
        idle();
        wait_trig(20, n);
        chk("bp_rx_bytes", rx_bytes, 64'd18);
        chk("bp_rx_good", rx_good, 64'd1);

        // clear mid-frame: only post-clear 8 bytes count
        tx_beat(8'hFF, 0, 0); tx_beat(8'hFF, 0, 0);
        do_clear();
        chk("clr_snap_hold", rx_bytes, 64'd18);
        tx_beat(8'hFF, 1, 0);
        wait_trig(20, n);
        chk("clr_trig_spacing", 64'(n + 1), 64'd10);
        chk("clr_tx_bytes", tx_bytes, 64'd8);
        chk("clr_tx_good", tx_good, 64'd1);

        // frame ending with enable=0 is dropped, no triggers meanwhile
        enable = 0;
        tx_beat(8'hFF, 1, 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (trigger) cnt++;
        end
        chk("dis_no_trig", 64'(cnt), 64'd0);
        enable = 1;
        wait_trig(20, n);
        chk("dis_tx_bytes", tx_bytes, 64'd8);
        chk("dis_tx_good", tx_good, 64'd1);

        // lowering period below current count fires on the next edge
        sample_period = 32'd100;
        do_clear();
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (trigger) cnt++;
        end
        chk("p100_no_trig", 64'(cnt), 64'd0);
        sample_period = 32'd5;
        tick();
        chk("p5_immediate", {63'd0, trigger}, 64'd1);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (trigger) cnt++;
        end
        chk("p5_gap", 64'(cnt), 64'd0);
        tick();
        chk("p5_period", {63'd0, trigger}, 64'd1);

        // 64-bit wrap of live totals
        force dut.u_tx.bytes_q = 64'hFFFF_FFFF_FFFF_FFFF;
        force dut.u_tx.good_q  = 64'hFFFF_FFFF_FFFF_FFFF;
        m_bytes[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        m_good[0]  = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.u_tx.bytes_q;
        release dut.u_tx.good_q;
        tx_beat(8'h01, 1, 0);
        wait_trig(20, n);
        chk("wrap_tx_bytes", tx_bytes, 64'd0);
        chk("wrap_tx_good", tx_good, 64'd0);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
